// File: rtl/alpaca_dtypes_pkg.sv
// Shared data types for the playback block: complex sample, FSM state enum,
// and a saturating counter helper.
package alpaca_dtypes_pkg;

    localparam int CX_W = 16;

    // One complex sample; real part in the upper half of the packed word.
    typedef struct packed {
        logic signed [CX_W-1:0] re;
        logic signed [CX_W-1:0] im;
    } cx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } playback_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// (1-cycle) read. Contents are deliberately not reset.
module sdp_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 64,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage write and registered read (read-before-write on collision).
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/parallel_axis_playback.sv
// Plays back a preloaded memory of SAMP_PER_CLK-wide complex beats as an
// AXI-Stream, with frame markers, looping, frame-aligned stop and a
// 2-entry skid buffer so tvalid never depends combinationally on tready.
module parallel_axis_playback
    import alpaca_dtypes_pkg::*;
#(
    parameter int SAMP_PER_CLK = 2,
    parameter int FFT_LEN      = 64,
    parameter int FRAMES       = 1,
    parameter int DEPTH        = FRAMES * (FFT_LEN / SAMP_PER_CLK),
    localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int BEATS       = FFT_LEN / SAMP_PER_CLK,
    localparam int PW          = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int DW          = SAMP_PER_CLK * $bits(cx_t)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  cx_t  [SAMP_PER_CLK-1:0]      wr_data,
    input  logic                         start,
    input  logic                         loop,
    input  logic                         stop,
    output cx_t  [SAMP_PER_CLK-1:0]      m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic [0:0]                   m_axis_tuser,
    output logic                         busy,
    output logic [31:0]                  frame_cnt,
    output logic                         err_wr_busy
);

    playback_state_t r_state;
    logic [AW-1:0]   r_addr;
    logic [PW-1:0]   r_pos;        // beat index within the current frame
    logic            r_stop_pend;
    logic            r_busy;
    logic            r_err;
    logic [31:0]     r_frame_cnt;

    // Read issued last cycle; its data and frame markers land this cycle.
    logic            r_rd_vld;
    logic            r_rd_last;
    logic            r_rd_user;

    // Skid buffer: slot 0 drives the output, slot 1 catches the in-flight read.
    logic            r_vld0;
    logic            r_vld1;
    logic [DW-1:0]   r_data0;
    logic [DW-1:0]   r_data1;
    logic            r_last0;
    logic            r_last1;
    logic            r_user0;
    logic            r_user1;

    logic [DW-1:0]   w_rd_data;
    logic            w_pop;
    logic [1:0]      w_occ;
    logic            w_can_issue;
    logic            w_issue;
    logic            w_frame_end;
    logic            w_mem_end;
    logic            w_stop_now;
    logic            w_done;

    sdp_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DW)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (wr_en & ~r_busy),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_issue),
        .i_rd_addr (r_addr),
        .o_rd_data (w_rd_data)
    );

    assign w_pop       = r_vld0 & m_axis_tready;
    assign w_occ       = {1'b0, r_vld0} + {1'b0, r_vld1} + {1'b0, r_rd_vld};
    // A new read is allowed only if the buffer can still hold it after this cycle's pop.
    assign w_can_issue = ((w_occ - {1'b0, w_pop}) < 2'd2);
    assign w_issue     = (r_state == PRIME) | ((r_state == STREAM) & w_can_issue);
    assign w_frame_end = (r_pos == PW'(BEATS - 1));
    assign w_mem_end   = (r_addr == AW'(DEPTH - 1));
    assign w_stop_now  = r_stop_pend | stop;
    assign w_done      = ~r_rd_vld & ~r_vld1 & (w_pop | ~r_vld0);

    // Playback sequencer: read address, frame position, stop flag and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_pos       <= '0;
            r_stop_pend <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_addr <= '0;
                    r_pos  <= '0;
                    if (start) begin
                        r_state     <= PRIME;
                        r_busy      <= 1'b1;
                        r_stop_pend <= stop;
                    end else begin
                        r_stop_pend <= 1'b0;
                    end
                end
                PRIME, STREAM: begin
                    if (w_issue) begin
                        if ((w_frame_end & w_stop_now) | (w_mem_end & ~loop)) begin
                            r_state     <= DRAIN;
                            r_stop_pend <= 1'b0;
                        end else begin
                            r_state     <= STREAM;
                            r_stop_pend <= w_stop_now;
                            r_addr      <= w_mem_end ? '0 : (r_addr + AW'(1));
                            r_pos       <= w_frame_end ? '0 : (r_pos + PW'(1));
                        end
                    end else begin
                        r_state     <= STREAM;
                        r_stop_pend <= w_stop_now;
                    end
                end
                DRAIN: begin
                    if (w_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_stop_pend <= 1'b0;
                end
            endcase
        end
    end

    // Side-band markers travel with the read through the RAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
            r_rd_user <= 1'b0;
        end else begin
            r_rd_vld  <= w_issue;
            r_rd_last <= w_frame_end;
            r_rd_user <= (r_pos == PW'(0));
        end
    end

    // Skid buffer: pop from slot 0, compact slot 1 forward, append read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld0  <= 1'b0;
            r_vld1  <= 1'b0;
            r_data0 <= '0;
            r_data1 <= '0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
            r_user0 <= 1'b0;
            r_user1 <= 1'b0;
        end else if (w_pop) begin
            r_vld0  <= r_vld1 | r_rd_vld;
            r_vld1  <= r_vld1 & r_rd_vld;
            if (r_vld1) begin
                r_data0 <= r_data1;
                r_last0 <= r_last1;
                r_user0 <= r_user1;
                r_data1 <= w_rd_data;
                r_last1 <= r_rd_last;
                r_user1 <= r_rd_user;
            end else begin
                r_data0 <= w_rd_data;
                r_last0 <= r_rd_last;
                r_user0 <= r_rd_user;
            end
        end else if (r_rd_vld) begin
            if (!r_vld0) begin
                r_vld0  <= 1'b1;
                r_data0 <= w_rd_data;
                r_last0 <= r_rd_last;
                r_user0 <= r_rd_user;
            end else begin
                r_vld1  <= 1'b1;
                r_data1 <= w_rd_data;
                r_last1 <= r_rd_last;
                r_user1 <= r_rd_user;
            end
        end else begin
            r_vld0 <= r_vld0;
        end
    end

    // Completed-frame counter and sticky write-while-busy error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            if (w_pop & r_last0) begin
                r_frame_cnt <= sat_inc32(r_frame_cnt);
            end
            if (wr_en & r_busy) begin
                r_err <= 1'b1;
            end
        end
    end

    assign m_axis_tdata  = r_data0;
    assign m_axis_tvalid = r_vld0;
    assign m_axis_tlast  = r_last0;
    assign m_axis_tuser  = r_user0;
    assign busy          = r_busy;
    assign frame_cnt     = r_frame_cnt;
    assign err_wr_busy   = r_err;

endmodule

// File: tb/tb_parallel_axis_playback.sv
// Scoreboard bench for parallel_axis_playback with FRAMES=2 (64 beats,
// 32 beats per frame). Expected beats come from a shadow copy of the memory.
module tb_parallel_axis_playback;

    localparam int NBEATS = 64;
    localparam int FBEATS = 32;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic        u;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [63:0] wr_data;
    logic        start;
    logic        loop_i;
    logic        stop;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tuser;
    logic        busy;
    logic [31:0] frame_cnt;
    logic        err_wr_busy;

    parallel_axis_playback #(
        .SAMP_PER_CLK (2),
        .FFT_LEN      (64),
        .FRAMES       (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .start         (start),
        .loop          (loop_i),
        .stop          (stop),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .err_wr_busy   (err_wr_busy)
    );

    logic [63:0] shadow [NBEATS];
    beat_t       q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          hs_cnt = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    int          exp_frames = 0;
    logic        rand_mode = 1'b0;
    logic        held = 1'b0;
    beat_t       held_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Output monitor: drives tready, checks stall stability, pops the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            m_axis_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held) begin
                chk("hold_valid", 64'(m_axis_tvalid), 64'(1));
                chk("hold_data",  m_axis_tdata, held_b.d);
                chk("hold_last",  64'(m_axis_tlast), 64'(held_b.l));
                chk("hold_user",  64'(m_axis_tuser), 64'(held_b.u));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (hs_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                hs_cnt++;
                chk("beat_expected", 64'(q.size() != 0), 64'(1));
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("tdata", m_axis_tdata, e.d);
                    chk("tlast", 64'(m_axis_tlast), 64'(e.l));
                    chk("tuser", 64'(m_axis_tuser), 64'(e.u));
                end
                held = 1'b0;
            end else if (m_axis_tvalid) begin
                held = 1'b1;
                held_b = '{d: m_axis_tdata, l: m_axis_tlast, u: m_axis_tuser[0]};
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic write_word(input int a, input logic [63:0] d, input bit while_busy);
        wr_en   = 1'b1;
        wr_addr = 6'(a);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (!while_busy) shadow[a] = d;
    endtask

    task automatic push_beats(input int first_addr, input int n);
        for (int i = 0; i < n; i++) begin
            int a;
            int p;
            a = (first_addr + i) % NBEATS;
            p = a % FBEATS;
            q.push_back('{d: shadow[a], l: (p == FBEATS - 1), u: (p == 0)});
            if (p == FBEATS - 1) exp_frames++;
        end
    endtask

    task automatic play(input logic lp, input logic st);
        int lat;
        hs_cnt = 0;
        start  = 1'b1;
        stop   = st;
        loop_i = lp;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        lat   = 0;
        while (!m_axis_tvalid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("start_latency", 64'(lat), 64'(2));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_in_time", 64'(n < budget), 64'(1));
        chk("tvalid_idle", 64'(m_axis_tvalid), 64'(0));
        chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    endtask

    task automatic wait_hs(input int n);
        int guard;
        guard = 0;
        while (hs_cnt < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_beat", 64'(hs_cnt >= n), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        wr_addr = 6'd0;
        wr_data = 64'd0;
        start = 1'b0;
        loop_i = 1'b0;
        stop = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_tlast",  64'(m_axis_tlast), 64'(0));
        chk("rst_tuser",  64'(m_axis_tuser), 64'(0));
        chk("rst_busy",   64'(busy), 64'(0));
        chk("rst_frames", 64'(frame_cnt), 64'(0));
        chk("rst_err",    64'(err_wr_busy), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp load: sample j of word k has re=2k+j, im tagged with k.
        for (int k = 0; k < NBEATS; k++) begin
            write_word(k, {16'(2*k+1), 16'(16'hA000 + k), 16'(2*k), 16'(16'hA000 + k)}, 1'b0);
        end

        // One frame, tready high: 32 back-to-back beats.
        rand_mode = 1'b0;
        push_beats(0, FBEATS);
        play(1'b0, 1'b1);
        wait_idle(500);
        chk("no_bubbles_1f", 64'(last_cyc - first_cyc + 1), 64'(FBEATS));
        chk("busy_after", 64'(busy), 64'(0));

        // Same frame with random backpressure.
        rand_mode = 1'b1;
        push_beats(0, FBEATS);
        play(1'b0, 1'b1);
        wait_idle(1000);
        chk("beats_rand", 64'(hs_cnt), 64'(FBEATS));

        // Whole memory, no loop.
        rand_mode = 1'b0;
        push_beats(0, NBEATS);
        play(1'b0, 1'b0);
        wait_idle(500);
        chk("no_bubbles_2f", 64'(last_cyc - first_cyc + 1), 64'(NBEATS));

        // Loop with stop at beat 40: ends on the tlast at address 63.
        rand_mode = 1'b1;
        push_beats(0, NBEATS);
        play(1'b1, 1'b0);
        wait_hs(40);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle(2000);
        chk("beats_stop40", 64'(hs_cnt), 64'(NBEATS));

        // Loop for 200 beats then drop loop: finishes at address 63 of that pass.
        rand_mode = 1'b0;
        push_beats(0, 4 * NBEATS);
        play(1'b1, 1'b0);
        wait_hs(200);
        loop_i = 1'b0;
        wait_idle(2000);
        chk("beats_loop", 64'(hs_cnt), 64'(4 * NBEATS));
        chk("no_bubbles_loop", 64'(last_cyc - first_cyc + 1), 64'(4 * NBEATS));

        // Write while busy is dropped and flagged.
        push_beats(0, NBEATS);
        play(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        write_word(5, 64'hDEAD_BEEF_0BAD_F00D, 1'b1);
        chk("err_wr_busy", 64'(err_wr_busy), 64'(1));
        wait_idle(500);
        push_beats(0, FBEATS);
        play(1'b0, 1'b1);
        wait_idle(500);
        chk("err_sticky", 64'(err_wr_busy), 64'(1));

        // Reset at beat 10 aborts; replay starts from word 0.
        rand_mode = 1'b1;
        push_beats(0, NBEATS);
        play(1'b0, 1'b0);
        wait_hs(10);
        rst_n = 1'b0;
        #1;
        chk("async_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("async_busy", 64'(busy), 64'(0));
        chk("async_frames", 64'(frame_cnt), 64'(0));
        chk("async_err", 64'(err_wr_busy), 64'(0));
        q.delete();
        exp_frames = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_beats(0, FBEATS);
        play(1'b0, 1'b1);
        chk("replay_tuser", 64'(m_axis_tuser), 64'(1));
        chk("replay_word0", m_axis_tdata, shadow[0]);
        wait_idle(1000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/parallel_axis_playback.md
PARALLEL_AXIS_PLAYBACK -- requirements
Module: parallel_axis_playback

Interface
REQ-001 Parameter SAMP_PER_CLK, default 2: complex samples carried per AXIS beat.
REQ-002 Parameter FFT_LEN, default 64: samples per frame.
REQ-003 Parameter FRAMES, default 1: frames held in the playback memory.
REQ-004 Parameter DEPTH, default FRAMES*(FFT_LEN/SAMP_PER_CLK): memory depth in beats; AW=$clog2(DEPTH).
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 wr_en  input  1  load-port write strobe.
REQ-009 wr_addr  input  AW  load-port beat address.
REQ-010 wr_data  input  SAMP_PER_CLK x cx_t  load-port beat data.
REQ-011 start  input  1  single-cycle pulse that begins playback at address 0.
REQ-012 loop  input  1  level; when high, playback wraps to address 0 after the last beat instead of stopping.
REQ-013 stop  input  1  single-cycle pulse requesting an end of playback at the next frame boundary.
REQ-014 m_axis  alpaca_data_pkt_axis.MST (dtype cx_t, SAMP_PER_CLK, TUSER=1)  tdata/tvalid/tready/tlast/tuser output stream.
REQ-015 busy  output  1  high from the start acceptance until the final beat handshake.
REQ-016 frame_cnt  output  32  count of frames fully transmitted since reset, saturating.
REQ-017 err_wr_busy  output  1  sticky; set when wr_en is asserted while busy.

Function
REQ-018 States IDLE, PRIME, STREAM, DRAIN; start in IDLE moves to PRIME and is ignored in all other states.
REQ-019 PRIME issues the read of address 0 (1-cycle memory latency) and moves to STREAM the next cycle, with tvalid rising 2 cycles after start.
REQ-020 In STREAM, beat k carries memory word k; tdata, tlast and tuser hold stable while tvalid=1 and tready=0.
REQ-021 With tready held high, the block delivers one beat per clk with no bubbles; a 2-entry output skid buffer absorbs read latency, keeping the tready-to-tvalid path registered.
REQ-022 tlast=1 on every beat whose address mod (FFT_LEN/SAMP_PER_CLK) equals FFT_LEN/SAMP_PER_CLK-1.
REQ-023 tuser[0]=1 on every beat whose address mod (FFT_LEN/SAMP_PER_CLK) equals 0, and 0 otherwise.
REQ-024 After the read of address DEPTH-1: loop=1 wraps the read address to 0 seamlessly; loop=0 moves to DRAIN.
REQ-025 A stop pulse latches a pending flag; at the next tlast read, the read address stops advancing and the state moves to DRAIN.
REQ-026 DRAIN issues no further reads, returns to IDLE once the skid buffer empties on the final handshake, and deasserts busy in the same cycle.
REQ-027 frame_cnt increments on each tlast handshake (tvalid and tready both high), saturating at 2^32-1.
REQ-028 A write while not busy updates the memory in one cycle.
REQ-029 A write while busy is dropped, sets err_wr_busy, and leaves the memory unchanged.
REQ-030 start and stop in the same cycle from IDLE: start is accepted and stop is latched, so exactly one frame is played.
REQ-031 Deasserting loop mid-playback takes effect at the next DEPTH-1 wrap point.

Reset
REQ-032 rst_n low forces the IDLE state, tvalid=0, tlast=0, tuser=0, busy=0, frame_cnt=0, err_wr_busy=0, an empty skid buffer and a cleared stop flag.
REQ-033 Memory contents are not reset.
REQ-034 Reset mid-stream aborts immediately with no further beats; the next start replays from address 0.

Structure
REQ-035 cx_t and the playback_state_t enum belong in alpaca_dtypes_pkg; there are no local type definitions.
REQ-036 The memory is the sub-module sdp_ram, a simple dual-port RAM of DEPTH x (SAMP_PER_CLK*$bits(cx_t)) with 1-cycle registered read.

Verification
REQ-037 Load ramp word k={2k,2k+1}, FRAMES=1, tready=1, start: 32 beats in 32 consecutive cycles, tlast on beat 31, tuser on beat 0, frame_cnt=1, busy low afterwards.
REQ-038 Same load with tready random at 50%: the beat sequence is identical to the previous case, no beat is lost or duplicated, and data holds stable during stalls.
REQ-039 FRAMES=2, loop=1, stop pulsed at beat 40: streaming stops after beat 63 (second tlast), giving frame_cnt=2.
REQ-040 FRAMES=2, loop=1 held for 200 beats then dropped: output follows the address sequence 0..63,0..63,... and ends on the tlast of the frame in progress at address 63, with no gap at the wraps.
REQ-041 wr_en pulsed at address 5 while busy: err_wr_busy=1, and a replay shows the original word 5.
REQ-042 rst_n low at beat 10 then start again: tvalid goes low asynchronously, frame_cnt=0, and the replay begins at word 0 with tuser=1.
